demux_steer_ctl: RTL and testbench

//  Clocked scheduler that drives the select pair (ctl_a/ctl_b) of a 2-way async demux.

---
 rtl/demux_ctl_pkg.sv | 13 +
 rtl/sync_ff.sv | 20 ++
 rtl/demux_steer_ctl.sv | 169 ++++++++++++++++
 tb/tb_demux_steer_ctl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_ctl_pkg.sv
// Shared state encoding and destination constants for the async-demux steering controller.
package demux_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } dsc_state_t;

  localparam logic DSC_OUT0 = 1'b0;
  localparam logic DSC_OUT1 = 1'b1;

endpackage

// File: rtl/sync_ff.sv
// N-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/demux_steer_ctl.sv
// Credit-gated round-robin scheduler driving the select pair of a 2-way async demux
// over a four-phase return-to-zero handshake closed through a synchronized ack.
module demux_steer_ctl
  import demux_ctl_pkg::*;
#(
  parameter int CRED_W = 4,
  parameter int CRED0  = 4,
  parameter int CRED1  = 4,
  parameter int SYNC_N = 2,
  parameter int TMO_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              force_en,
  input  logic              force_sel,
  output logic              ctl_a,
  output logic              ctl_b,
  input  logic              actl_i,
  input  logic              crd0_ret,
  input  logic              crd1_ret,
  output logic              busy,
  output logic [CRED_W-1:0] crd0,
  output logic [CRED_W-1:0] crd1,
  output logic              err_ovf,
  output logic              err_tmo
);

  localparam logic [CRED_W-1:0] CRED0_MAX = CRED_W'(CRED0);
  localparam logic [CRED_W-1:0] CRED1_MAX = CRED_W'(CRED1);
  localparam logic [TMO_W-1:0]  WDG_MAX   = '1;

  dsc_state_t        state_q, state_d;
  logic              ctl_a_q, ctl_a_d, ctl_b_q, ctl_b_d;
  logic              rr_last_q, rr_last_d;
  logic [CRED_W-1:0] crd0_q, crd0_d, crd1_q, crd1_d;
  logic              err_ovf_q, err_ovf_d, err_tmo_q, err_tmo_d;
  logic [TMO_W-1:0]  wdg_q, wdg_d;

  logic ack_s;
  logic has0, has1;
  logic cand_vld, cand_sel;
  logic grant, dec0, dec1;

  sync_ff #(.N(SYNC_N)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (actl_i),
    .q_o (ack_s)
  );

  assign has0 = (crd0_q != '0);
  assign has1 = (crd1_q != '0);

  // Round-robin prefers the output not granted last; force mode pins the choice.
  always_comb begin
    cand_vld = 1'b0;
    cand_sel = DSC_OUT0;
    if (force_en) begin
      cand_sel = force_sel;
      cand_vld = force_sel ? has1 : has0;
    end else if (rr_last_q ? has0 : has1) begin
      cand_sel = ~rr_last_q;
      cand_vld = 1'b1;
    end else if (rr_last_q ? has1 : has0) begin
      cand_sel = rr_last_q;
      cand_vld = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ctl_a_d = ctl_a_q;
    ctl_b_d = ctl_b_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ctl_a_d = 1'b0;
        ctl_b_d = 1'b0;
        if (en && !ack_s && cand_vld) begin
          grant   = 1'b1;
          ctl_a_d = (cand_sel == DSC_OUT0);
          ctl_b_d = (cand_sel == DSC_OUT1);
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        if (ack_s) begin
          ctl_a_d = 1'b0;
          ctl_b_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        ctl_a_d = 1'b0;
        ctl_b_d = 1'b0;
        if (!ack_s) state_d = IDLE;
      end
      default: begin
        ctl_a_d = 1'b0;
        ctl_b_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign dec0      = grant && (cand_sel == DSC_OUT0);
  assign dec1      = grant && (cand_sel == DSC_OUT1);
  assign rr_last_d = grant ? cand_sel : rr_last_q;

  // A return that coincides with a grant cancels it and is never an overflow.
  function automatic logic [CRED_W-1:0] crd_next(input logic [CRED_W-1:0] crd,
                                                 input logic dec, input logic ret,
                                                 input logic [CRED_W-1:0] max);
    logic [CRED_W-1:0] nxt;
    nxt = crd;
    if (dec && !ret)                    nxt = crd - CRED_W'(1);
    else if (ret && !dec && crd != max) nxt = crd + CRED_W'(1);
    return nxt;
  endfunction

  assign crd0_d    = crd_next(crd0_q, dec0, crd0_ret, CRED0_MAX);
  assign crd1_d    = crd_next(crd1_q, dec1, crd1_ret, CRED1_MAX);
  assign err_ovf_d = err_ovf_q
                   | (crd0_ret && !dec0 && crd0_q == CRED0_MAX)
                   | (crd1_ret && !dec1 && crd1_q == CRED1_MAX);

  // Watchdog only flags a stuck handshake; the FSM keeps waiting for the ack.
  always_comb begin
    wdg_d = wdg_q;
    if (state_d != state_q)                       wdg_d = '0;
    else if (state_q != IDLE && wdg_q != WDG_MAX) wdg_d = wdg_q + TMO_W'(1);
  end

  assign err_tmo_d = err_tmo_q | (state_q != IDLE && wdg_d == WDG_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ctl_a_q   <= 1'b0;
      ctl_b_q   <= 1'b0;
      rr_last_q <= DSC_OUT1;
      crd0_q    <= CRED0_MAX;
      crd1_q    <= CRED1_MAX;
      err_ovf_q <= 1'b0;
      err_tmo_q <= 1'b0;
      wdg_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctl_a_q   <= ctl_a_d;
      ctl_b_q   <= ctl_b_d;
      rr_last_q <= rr_last_d;
      crd0_q    <= crd0_d;
      crd1_q    <= crd1_d;
      err_ovf_q <= err_ovf_d;
      err_tmo_q <= err_tmo_d;
      wdg_q     <= wdg_d;
    end
  end

  assign ctl_a   = ctl_a_q;
  assign ctl_b   = ctl_b_q;
  assign busy    = (state_q != IDLE);
  assign crd0    = crd0_q;
  assign crd1    = crd1_q;
  assign err_ovf = err_ovf_q;
  assign err_tmo = err_tmo_q;

endmodule

// File: tb/tb_demux_steer_ctl.sv
// Directed bench for demux_steer_ctl with a 3-cycle-latency demux ack model.
module tb_demux_steer_ctl;

  logic       clk = 1'b0;
  logic       rst, en, force_en, force_sel, actl_i, crd0_ret, crd1_ret;
  logic       ctl_a, ctl_b, busy, err_ovf, err_tmo;
  logic [3:0] crd0, crd1;
  logic       ack_auto;
  logic [2:0] hist;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  demux_steer_ctl dut (
    .clk(clk), .rst(rst), .en(en), .force_en(force_en), .force_sel(force_sel),
    .ctl_a(ctl_a), .ctl_b(ctl_b), .actl_i(actl_i), .crd0_ret(crd0_ret), .crd1_ret(crd1_ret),
    .busy(busy), .crd0(crd0), .crd1(crd1), .err_ovf(err_ovf), .err_tmo(err_tmo)
  );

  // Demux model: ack mirrors the select three cycles late.
  always @(negedge clk) begin
    if (ack_auto) begin
      hist   = {hist[1:0], ctl_a | ctl_b};
      actl_i = hist[2];
    end else begin
      hist = 3'b0;
    end
  end

  task automatic wait_ctl(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ctl_a || ctl_b) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!ctl_a && !ctl_b && !busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_ret(input bit which);
    @(negedge clk);
    if (which) crd1_ret = 1'b1; else crd0_ret = 1'b1;
    @(negedge clk);
    crd0_ret = 1'b0;
    crd1_ret = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; force_en = 1'b0; force_sel = 1'b0;
    actl_i = 1'b0; crd0_ret = 1'b0; crd1_ret = 1'b0; ack_auto = 1'b1; hist = 3'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({ctl_a, ctl_b, busy, err_ovf, err_tmo, crd0, crd1} !== {5'b0, 4'd4, 4'd4}) begin
      bad++;
      $display("FAIL reset_state got ctl=%b%b busy=%b ovf=%b tmo=%b crd=%0d/%0d want 00 0 0 0 4/4",
               ctl_a, ctl_b, busy, err_ovf, err_tmo, crd0, crd1);
    end
  endtask

  task automatic test_alternate();
    bit ok;
    logic exp_a;
    int e0, e1;
    bit stray;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_ctl(ok);
      exp_a = (i % 2 == 0);
      e0 = 4 - (i + 2) / 2;
      e1 = 4 - (i + 1) / 2;
      total++;
      if (!ok || ctl_a !== exp_a || ctl_b !== !exp_a || crd0 != e0 || crd1 != e1) begin
        bad++;
        $display("FAIL alt_grant%0d ok=%0d ctl=%b%b crd=%0d/%0d want ctl=%b%b crd=%0d/%0d",
                 i, ok, ctl_a, ctl_b, crd0, crd1, exp_a, !exp_a, e0, e1);
      end
      wait_idle(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL alt_idle%0d handshake did not complete, want idle", i); end
    end
    stray = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ctl_a || ctl_b || busy) stray = 1'b1;
    end
    total++;
    if (stray || crd0 !== 4'd0 || crd1 !== 4'd0) begin
      bad++;
      $display("FAIL exhausted stray=%0d crd=%0d/%0d want stray=0 crd=0/0", stray, crd0, crd1);
    end
  endtask

  task automatic test_starve();
    bit ok;
    bit stray;
    en = 1'b0;
    pulse_ret(1'b1);
    pulse_ret(1'b1);
    total++;
    if (crd0 !== 4'd0 || crd1 !== 4'd2) begin
      bad++; $display("FAIL starve_setup crd=%0d/%0d want 0/2", crd0, crd1);
    end
    for (int i = 0; i < 2; i++) begin
      en = 1'b1;
      wait_ctl(ok);
      en = 1'b0;
      total++;
      if (!ok || ctl_a !== 1'b0 || ctl_b !== 1'b1 || crd1 != 1 - i) begin
        bad++;
        $display("FAIL starve_b%0d ok=%0d ctl=%b%b crd1=%0d want ctl=01 crd1=%0d", i, ok, ctl_a, ctl_b, crd1, 1 - i);
      end
      wait_idle(ok);
    end
    en = 1'b1;
    stray = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ctl_a || ctl_b) stray = 1'b1;
    end
    total++;
    if (stray) begin bad++; $display("FAIL starve_nocredit got a grant, want none"); end
    pulse_ret(1'b0);
    wait_ctl(ok);
    total++;
    if (!ok || ctl_a !== 1'b1 || ctl_b !== 1'b0 || crd0 !== 4'd0) begin
      bad++;
      $display("FAIL starve_ret_a ok=%0d ctl=%b%b crd0=%0d want ctl=10 crd0=0", ok, ctl_a, ctl_b, crd0);
    end
    wait_idle(ok);
    en = 1'b0;
  endtask

  task automatic test_same_cycle();
    bit ok;
    pulse_ret(1'b0);
    @(negedge clk);
    en = 1'b1;
    crd0_ret = 1'b1;
    @(negedge clk);
    en = 1'b0;
    crd0_ret = 1'b0;
    total++;
    if (ctl_a !== 1'b1 || crd0 !== 4'd1) begin
      bad++; $display("FAIL same_cycle ctl_a=%b crd0=%0d want ctl_a=1 crd0=1", ctl_a, crd0);
    end
    wait_idle(ok);
    repeat (3) pulse_ret(1'b0);
    total++;
    if (crd0 !== 4'd4 || err_ovf !== 1'b0) begin
      bad++; $display("FAIL fill_to_max crd0=%0d ovf=%b want 4 0", crd0, err_ovf);
    end
    pulse_ret(1'b0);
    total++;
    if (crd0 !== 4'd4 || err_ovf !== 1'b1) begin
      bad++; $display("FAIL overflow crd0=%0d ovf=%b want 4 1", crd0, err_ovf);
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    @(negedge clk);
    ack_auto = 1'b0;
    actl_i = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    wait_ctl(ok);
    en = 1'b0;
    total++;
    if (!ok || ctl_a !== 1'b1) begin bad++; $display("FAIL wdg_grant ok=%0d ctl_a=%b want 1", ok, ctl_a); end
    repeat (200) @(negedge clk);
    total++;
    if (err_tmo !== 1'b0 || ctl_a !== 1'b1) begin
      bad++; $display("FAIL wdg_early tmo=%b ctl_a=%b want 0 1", err_tmo, ctl_a);
    end
    repeat (60) @(negedge clk);
    total++;
    if (err_tmo !== 1'b1 || ctl_a !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL wdg_expired tmo=%b ctl_a=%b busy=%b want 1 1 1", err_tmo, ctl_a, busy);
    end
    actl_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ctl_a) begin ok = 1'b1; break; end
    end
    actl_i = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL wdg_release ctl_a stayed %b want 0", ctl_a); end
    wait_idle(ok);
    total++;
    if (!ok || crd0 !== 4'd3 || err_tmo !== 1'b1) begin
      bad++; $display("FAIL wdg_done ok=%0d crd0=%0d tmo=%b want 1 3 1", ok, crd0, err_tmo);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    en = 1'b1;
    wait_ctl(ok);
    en = 1'b0;
    total++;
    if (!ok || ctl_a !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL mid_grant ok=%0d ctl_a=%b busy=%b want 1 1", ok, ctl_a, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({ctl_a, ctl_b, busy, err_ovf, err_tmo, crd0, crd1} !== {5'b0, 4'd4, 4'd4}) begin
      bad++;
      $display("FAIL mid_reset ctl=%b%b busy=%b ovf=%b tmo=%b crd=%0d/%0d want 00 0 0 0 4/4",
               ctl_a, ctl_b, busy, err_ovf, err_tmo, crd0, crd1);
    end
  endtask

  task automatic test_force();
    bit ok;
    ack_auto = 1'b1;
    force_en = 1'b1;
    force_sel = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en = 1'b1;
      wait_ctl(ok);
      en = 1'b0;
      total++;
      if (!ok || ctl_a !== 1'b0 || ctl_b !== 1'b1 || crd0 !== 4'd4 || crd1 != 3 - i) begin
        bad++;
        $display("FAIL force_b%0d ok=%0d ctl=%b%b crd=%0d/%0d want 01 4/%0d", i, ok, ctl_a, ctl_b, crd0, crd1, 3 - i);
      end
      wait_idle(ok);
    end
    force_en = 1'b0;
  endtask

  task automatic test_random_ack();
    bit both;
    both = 1'b0;
    ack_auto = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      actl_i = 1'($urandom_range(0, 1));
      if (i % 17 == 0) crd0_ret = 1'b1; else crd0_ret = 1'b0;
      if (i % 23 == 0) crd1_ret = 1'b1; else crd1_ret = 1'b0;
      if (ctl_a && ctl_b) both = 1'b1;
    end
    crd0_ret = 1'b0;
    crd1_ret = 1'b0;
    en = 1'b0;
    total++;
    if (both) begin bad++; $display("FAIL random_exclusive ctl_a and ctl_b were both 1, want never"); end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_starve();
    test_same_cycle();
    test_watchdog();
    test_reset_mid();
    test_force();
    test_random_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
